// File: rtl/network_pkg.sv
// Shared types and constants for the network readout path.
// Holds the classifier FSM encoding and the default spike-counter width.
package network_pkg;

   localparam int CLS_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      SCAN,
      DONE
   } classifier_state_t;

endpackage

// File: rtl/spike_counter.sv
// Per-neuron saturating spike counter with a sticky flag that records
// whether the counter reached its maximum since the last clear.
module spike_counter
   import network_pkg::*;
#(
   parameter int CNT_W = CLS_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] count_reg;
   logic             sat_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
         sat_reg   <= 1'b0;
      end else if (clr) begin
         count_reg <= '0;
         sat_reg   <= 1'b0;
      end else if (en && inc && (count_reg != CNT_MAX)) begin
         count_reg <= count_reg + CNT_W'(1);
         if (count_reg == (CNT_MAX - CNT_W'(1)))
            sat_reg <= 1'b1;
      end
   end

   assign count = count_reg;
   assign sat   = sat_reg;

endmodule

// File: rtl/spike_classifier.sv
// Counts per-neuron spikes over a programmable window, then scans the counts
// one neuron per cycle to find the winning class and hands it off via valid/ready.
module spike_classifier
   import network_pkg::*;
#(
   parameter int NEURON_COUNT = 10,
   parameter int CNT_W        = CLS_CNT_W,
   parameter int IDX_W        = $clog2(NEURON_COUNT)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [15:0]             window_len,
   input  logic [NEURON_COUNT-1:0] spikes_in,
   output logic                    busy,
   output logic                    class_valid,
   input  logic                    class_ready,
   output logic [IDX_W-1:0]        class_idx,
   output logic [CNT_W-1:0]        class_count,
   output logic                    tie,
   output logic                    no_spike,
   output logic                    saturated
);

   classifier_state_t state_reg;
   logic [15:0]       remaining_reg;
   logic [IDX_W-1:0]  scan_idx_reg;
   logic [IDX_W-1:0]  best_idx_reg, best_idx_next;
   logic [CNT_W-1:0]  best_val_reg, best_val_next;
   logic              tie_acc_reg, tie_acc_next;

   logic              busy_reg, class_valid_reg, tie_reg, no_spike_reg, saturated_reg;
   logic [IDX_W-1:0]  class_idx_reg;
   logic [CNT_W-1:0]  class_count_reg;

   logic [CNT_W-1:0]        counts [NEURON_COUNT];
   logic [NEURON_COUNT-1:0] sat_vec;
   logic                    counter_clr, counter_en;
   logic [CNT_W-1:0]        scan_val;
   logic                    last_scan;

   assign counter_clr = (state_reg == IDLE) && start;
   assign counter_en  = (state_reg == COUNT);

   generate
      for (genvar gi = 0; gi < NEURON_COUNT; gi++) begin : g_cnt
         spike_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (counter_clr),
            .en    (counter_en),
            .inc   (spikes_in[gi]),
            .count (counts[gi]),
            .sat   (sat_vec[gi])
         );
      end
   endgenerate

   assign scan_val  = counts[scan_idx_reg];
   assign last_scan = (scan_idx_reg == IDX_W'(NEURON_COUNT - 1));

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      best_val_next = best_val_reg;
      best_idx_next = best_idx_reg;
      tie_acc_next  = tie_acc_reg;
      if (scan_idx_reg == '0) begin
         best_val_next = scan_val;
         best_idx_next = '0;
         tie_acc_next  = 1'b0;
      end else if (scan_val > best_val_reg) begin
         best_val_next = scan_val;
         best_idx_next = scan_idx_reg;
         tie_acc_next  = 1'b0;
      end else if ((scan_val == best_val_reg) && (scan_val != '0)) begin
         tie_acc_next  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         remaining_reg   <= '0;
         scan_idx_reg    <= '0;
         best_idx_reg    <= '0;
         best_val_reg    <= '0;
         tie_acc_reg     <= 1'b0;
         busy_reg        <= 1'b0;
         class_valid_reg <= 1'b0;
         class_idx_reg   <= '0;
         class_count_reg <= '0;
         tie_reg         <= 1'b0;
         no_spike_reg    <= 1'b0;
         saturated_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  remaining_reg <= window_len;
                  saturated_reg <= 1'b0;
                  busy_reg      <= 1'b1;
                  scan_idx_reg  <= '0;
                  state_reg     <= (window_len != 16'd0) ? COUNT : SCAN;
               end
            end
            COUNT: begin
               remaining_reg <= remaining_reg - 16'd1;
               if (remaining_reg == 16'd1)
                  state_reg <= SCAN;
            end
            SCAN: begin
               // Counters are frozen here, so their sticky flags are final.
               saturated_reg <= saturated_reg | (|sat_vec);
               best_val_reg  <= best_val_next;
               best_idx_reg  <= best_idx_next;
               tie_acc_reg   <= tie_acc_next;
               scan_idx_reg  <= scan_idx_reg + IDX_W'(1);
               if (last_scan) begin
                  state_reg       <= DONE;
                  scan_idx_reg    <= '0;
                  class_valid_reg <= 1'b1;
                  class_idx_reg   <= best_idx_next;
                  class_count_reg <= best_val_next;
                  no_spike_reg    <= (best_val_next == '0);
                  tie_reg         <= tie_acc_next && (best_val_next != '0);
               end
            end
            DONE: begin
               if (class_ready) begin
                  state_reg       <= IDLE;
                  class_valid_reg <= 1'b0;
                  busy_reg        <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy        = busy_reg;
   assign class_valid = class_valid_reg;
   assign class_idx   = class_idx_reg;
   assign class_count = class_count_reg;
   assign tie         = tie_reg;
   assign no_spike    = no_spike_reg;
   assign saturated   = saturated_reg;

endmodule
